trng_postproc: RTL

//  Downstream conditioning stage for the 16-bit SMFRO TRNG core. It samples the core's
//  raw state word and removes bias with a von Neumann extractor on each bit pair.

---
 rtl/trng_pkg.sv | 34 +++
 rtl/trng_fifo.sv | 64 ++++++
 rtl/trng_postproc.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/trng_pkg.sv
// Shared constants, types and the von Neumann extractor for the TRNG post-processor.
//   RAW_W    : width of the raw TRNG state word
//   OUT_W    : width of a conditioned output word
//   VN_PAIRS : bit pairs per raw word (max extracted bits per sample)
//   PACK_W   : packer accumulator width (31 held bits + 8 new bits)
//   vn_extract(raw) -> {count[3:0], bits[7:0]}, bits compacted LSB-first
package trng_pkg;

  localparam int unsigned RAW_W    = 16;
  localparam int unsigned OUT_W    = 32;
  localparam int unsigned VN_PAIRS = RAW_W / 2;
  localparam int unsigned PACK_W   = OUT_W + VN_PAIRS - 1;

  typedef struct packed {
    logic [3:0]          count;
    logic [VN_PAIRS-1:0] bits;
  } vn_t;

  // Pairs that differ emit their low bit; equal pairs are discarded. Survivors are packed
  // densely from bit 0 in ascending pair order, unused upper bits stay zero.
  function automatic vn_t vn_extract(input logic [RAW_W-1:0] raw);
    vn_t r;
    r.count = '0;
    r.bits  = '0;
    for (int i = 0; i < VN_PAIRS; i++) begin
      if (raw[2*i+1] != raw[2*i]) begin
        r.bits[r.count[2:0]] = raw[2*i];
        r.count              = r.count + 4'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/trng_fifo.sv
// Synchronous FIFO buffering conditioned words.
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_en      : push request; honoured when not full, or when full with a same-cycle pop
//   wr_data    : word to push
//   full       : DEPTH entries held
//   rd_en      : pop request; ignored when empty
//   rd_data    : head of FIFO (entry storage resets to zero)
//   empty      : no entries held
module trng_fifo
  import trng_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_wr, do_rd;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign rd_data = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal when the head leaves on the same edge.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_wr) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_rd) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      unique case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/trng_postproc.sv
// Conditioning stage behind the 16-bit SMFRO TRNG core: von Neumann debiasing, 32-bit
// packing, output FIFO and a repetition-count health test.
//   clk, rst_n  : core clock; asynchronous active-low reset, released synchronously upstream
//   raw_data    : raw TRNG state word
//   raw_valid   : sample raw_data on this edge (no backpressure)
//   out_data    : head of output FIFO
//   out_valid   : FIFO not empty and health test passing
//   out_ready   : consumer pops head when out_valid && out_ready
//   health_fail : sticky, source repeated REP_LIMIT times
//   overflow    : sticky, a completed word was dropped on a full FIFO
module trng_postproc
  import trng_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned REP_LIMIT  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RAW_W-1:0] raw_data,
  input  logic             raw_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             health_fail,
  output logic             overflow
);

  localparam int unsigned REP_W = $clog2(REP_LIMIT + 1);

  logic health_fail_q, overflow_q;

  // Stage 1: sample, extract, repetition test
  logic                accept;
  vn_t                 vn;
  logic                s1_valid_q;
  logic [VN_PAIRS-1:0] s1_bits_q;
  logic [3:0]          s1_cnt_q;
  logic [RAW_W-1:0]    raw_q;
  logic [REP_W-1:0]    rep_cnt_q, rep_cnt_d;
  logic                trip;

  assign accept = raw_valid && !health_fail_q;
  assign vn     = vn_extract(raw_data);

  // rep_cnt_q == 0 only before the first accepted word, so there is nothing to compare.
  always_comb begin
    rep_cnt_d = REP_W'(1);
    if (rep_cnt_q != '0 && raw_data == raw_q) begin
      rep_cnt_d = rep_cnt_q + REP_W'(1);
    end
  end

  assign trip = accept && (rep_cnt_d == REP_W'(REP_LIMIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_bits_q  <= '0;
      s1_cnt_q   <= '0;
      raw_q      <= '0;
      rep_cnt_q  <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_bits_q <= vn.bits;
        s1_cnt_q  <= vn.count;
        raw_q     <= raw_data;
        rep_cnt_q <= rep_cnt_d;
      end
    end
  end

  // Stage 2: packer. Held bits sit at the bottom, new bits are OR-ed in above them.
  logic [OUT_W-2:0]  pack_q, pack_d;
  logic [4:0]        pack_cnt_q, pack_cnt_d;
  logic [PACK_W-1:0] acc;
  logic [5:0]        total, total_m32;
  logic              pack_en, word_done;
  logic              fifo_full, fifo_empty, pop, push, ovf_set;
  logic [OUT_W-1:0]  fifo_rdata;

  assign pack_en   = s1_valid_q && !health_fail_q;
  assign acc       = {{(PACK_W-OUT_W+1){1'b0}}, pack_q} | (PACK_W'(s1_bits_q) << pack_cnt_q);
  assign total     = 6'(pack_cnt_q) + 6'(s1_cnt_q);
  assign total_m32 = total - 6'd32;
  assign word_done = pack_en && (total >= 6'd32);

  always_comb begin
    pack_d     = pack_q;
    pack_cnt_d = pack_cnt_q;
    if (pack_en) begin
      if (word_done) begin
        // Bits above the completed word carry over into the next one.
        pack_d     = {{(OUT_W-1-(PACK_W-OUT_W)){1'b0}}, acc[PACK_W-1:OUT_W]};
        pack_cnt_d = total_m32[4:0];
      end else begin
        pack_d     = acc[OUT_W-2:0];
        pack_cnt_d = total[4:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_q     <= '0;
      pack_cnt_q <= '0;
    end else begin
      pack_q     <= pack_d;
      pack_cnt_q <= pack_cnt_d;
    end
  end

  assign out_valid = !fifo_empty && !health_fail_q;
  assign pop       = out_valid && out_ready;
  assign push      = word_done && (!fifo_full || pop);
  assign ovf_set   = word_done && fifo_full && !pop;

  trng_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (OUT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (acc[OUT_W-1:0]),
    .full    (fifo_full),
    .rd_en   (pop),
    .rd_data (fifo_rdata),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      health_fail_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      health_fail_q <= health_fail_q | trip;
      overflow_q    <= overflow_q | ovf_set;
    end
  end

  assign out_data    = fifo_rdata;
  assign health_fail = health_fail_q;
  assign overflow    = overflow_q;

endmodule
